// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared types and constants for the main-RAM arbiter.
//   - RAM geometry: RAM_DEPTH 32-bit words, AW word-address bits.
//   - Cache line: BLK_SIZE bits, RAM_LINE_BYTES byte strobes.
//   - ram_arb_state_e : arbiter FSM states.
//   - ram_port_e      : requester identity (data cache / instruction cache).
//   - ram_req_t       : latched request (address, direction, data, strobes).
// Optional feature macro used by this slice: RAM_ARB_RR_EN (round-robin).
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

  localparam int RAM_DEPTH      = 32768;
  localparam int AW             = $clog2(RAM_DEPTH);
  localparam int BLK_SIZE       = 128;
  localparam int LINE_W         = BLK_SIZE;
  localparam int ADDR_W         = 32;
  localparam int RAM_LINE_BYTES = BLK_SIZE / 8;
  // Byte-offset bits inside one cache line; these address bits never reach the RAM.
  localparam int LINE_OFF_W     = $clog2(RAM_LINE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ram_arb_state_e;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } ram_port_e;

  typedef struct packed {
    logic [ADDR_W-1:0]         addr;
    logic                      we;
    logic [LINE_W-1:0]         wdata;
    logic [RAM_LINE_BYTES-1:0] wstrb;
  } ram_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundles every bus signal of the arbiter: the data-cache port (D), the
// instruction-cache port (I), the prog-mode hold, the RAM command/read-data
// path and the busy flag. Signal suffixes give direction as seen by the
// arbiter (_i into it, _o out of it).
//   modport slave  : the arbiter side.
//   modport master : the surrounding system (caches, RAM wrapper, programmer).
// ---------------------------------------------------------------------------
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  // Port D: data cache refill reads and writebacks
  logic                      d_req_valid_i;
  logic                      d_req_ready_o;
  logic [ADDR_W-1:0]         d_req_addr_i;
  logic                      d_req_we_i;
  logic [LINE_W-1:0]         d_req_wdata_i;
  logic [RAM_LINE_BYTES-1:0] d_req_wstrb_i;
  logic                      d_rsp_valid_o;
  logic                      d_rsp_ready_i;
  logic [LINE_W-1:0]         d_rsp_rdata_o;

  // Port I: instruction cache refill reads
  logic                      i_req_valid_i;
  logic                      i_req_ready_o;
  logic [ADDR_W-1:0]         i_req_addr_i;
  logic                      i_rsp_valid_o;
  logic                      i_rsp_ready_i;
  logic [LINE_W-1:0]         i_rsp_rdata_o;

  // Prog-mode hold from the UART programmer
  logic                      hold_i;

  // RAM wrapper command and read data
  logic [AW-1:0]             ram_addr_o;
  logic [LINE_W-1:0]         ram_wdata_o;
  logic [RAM_LINE_BYTES-1:0] ram_wstrb_o;
  logic                      ram_rd_en_o;
  logic [LINE_W-1:0]         ram_rdata_i;

  logic                      busy_o;

  modport slave (
    input  d_req_valid_i, d_req_addr_i, d_req_we_i, d_req_wdata_i, d_req_wstrb_i,
    input  d_rsp_ready_i,
    output d_req_ready_o, d_rsp_valid_o, d_rsp_rdata_o,
    input  i_req_valid_i, i_req_addr_i, i_rsp_ready_i,
    output i_req_ready_o, i_rsp_valid_o, i_rsp_rdata_o,
    input  hold_i,
    output ram_addr_o, ram_wdata_o, ram_wstrb_o, ram_rd_en_o,
    input  ram_rdata_i,
    output busy_o
  );

  modport master (
    output d_req_valid_i, d_req_addr_i, d_req_we_i, d_req_wdata_i, d_req_wstrb_i,
    output d_rsp_ready_i,
    input  d_req_ready_o, d_rsp_valid_o, d_rsp_rdata_o,
    output i_req_valid_i, i_req_addr_i, i_rsp_ready_i,
    input  i_req_ready_o, i_rsp_valid_o, i_rsp_rdata_o,
    output hold_i,
    input  ram_addr_o, ram_wdata_o, ram_wstrb_o, ram_rd_en_o,
    output ram_rdata_i,
    input  busy_o
  );

endinterface

// File: rtl/ram_arb_grant.sv
// ---------------------------------------------------------------------------
// ram_arb_grant
// Combinational one-hot grant between the D and I requesters.
//   i_d_valid / i_i_valid : requests already qualified by "arbiter may grant".
//   o_gnt_d / o_gnt_i     : at most one high.
// Default build: fixed priority, D over I; no state.
// With RAM_ARB_RR_EN defined: a 1-bit pointer names the preferred port on
// contention and moves to the non-granted port on every accepted grant
// (i_take). Extra ports i_clk / i_rst / i_take exist only in that build.
// ---------------------------------------------------------------------------
module ram_arb_grant
  import ram_arbiter_pkg::*;
(
`ifdef RAM_ARB_RR_EN
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_take,
`endif
  input  logic i_d_valid,
  input  logic i_i_valid,
  output logic o_gnt_d,
  output logic o_gnt_i
);

`ifdef RAM_ARB_RR_EN
  ram_port_e r_ptr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    o_gnt_d = 1'b0;
    o_gnt_i = 1'b0;
    if (i_d_valid && i_i_valid) begin
      // Pointer only matters on contention.
      if (r_ptr == PORT_D) o_gnt_d = 1'b1;
      else                 o_gnt_i = 1'b1;
    end else begin
      o_gnt_d = i_d_valid;
      o_gnt_i = i_i_valid;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= PORT_D;
    end else if (i_take) begin
      r_ptr <= o_gnt_d ? PORT_I : PORT_D;
    end
  end
`else
  assign o_gnt_d = i_d_valid;
  assign o_gnt_i = i_i_valid && !i_d_valid;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port, line-wide main RAM between the data cache (D:
// reads and writebacks) and the instruction cache (I: reads only).
// One transaction at a time: IDLE -> ISSUE -> (WAIT for reads) -> RESP.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset; an in-flight transaction is dropped
//   bus   : ram_arbiter_if.slave -- D/I request+response handshakes, hold_i
//           (no new grants while high), RAM command/read data, busy_o.
// Read latency from accept cycle T: rsp_valid at T+3; write ack at T+2.
// Arbitration: fixed D-over-I; round-robin when RAM_ARB_RR_EN is defined.
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input logic          clk_i,
  input logic          rst_i,
  ram_arbiter_if.slave bus
);

  ram_arb_state_e    r_state;
  ram_arb_state_e    w_state_nxt;
  ram_req_t          r_req;
  ram_port_e         r_owner;
  logic [LINE_W-1:0] r_rdata;

  logic w_open;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_accept;
  logic w_rsp_ready;
  logic w_rsp_hs;
  logic w_unused_addr;

  // Grants are only offered from IDLE with hold low; the reset term keeps the
  // combinational readies at 0 while reset is asserted.
  assign w_open   = (r_state == IDLE) && !bus.hold_i && !rst_i;
  assign w_accept = w_gnt_d || w_gnt_i;

  ram_arb_grant u_grant (
`ifdef RAM_ARB_RR_EN
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_take    (w_accept),
`endif
    .i_d_valid (bus.d_req_valid_i && w_open),
    .i_i_valid (bus.i_req_valid_i && w_open),
    .o_gnt_d   (w_gnt_d),
    .o_gnt_i   (w_gnt_i)
  );

  // A grant is only raised on a valid request, so ready doubles as handshake.
  assign bus.d_req_ready_o = w_gnt_d;
  assign bus.i_req_ready_o = w_gnt_i;

  assign w_rsp_ready = (r_owner == PORT_D) ? bus.d_rsp_ready_i : bus.i_rsp_ready_i;
  assign w_rsp_hs    = (r_state == RESP) && w_rsp_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      // Writes have nothing to wait for; reads need the RAM's registered cycle.
      ISSUE:   w_state_nxt = r_req.we ? RESP : WAIT;
      WAIT:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- Request latch and response register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the datapath registers are reset too (not just the FSM) because
      // they feed the RAM and response outputs, which must read 0 in reset.
      r_req   <= '0;
      r_owner <= PORT_D;
      r_rdata <= '0;
    end else begin
      if (w_gnt_d) begin
        r_owner <= PORT_D;
        r_req   <= '{addr:  bus.d_req_addr_i,
                     we:    bus.d_req_we_i,
                     wdata: bus.d_req_wdata_i,
                     wstrb: bus.d_req_wstrb_i};
      end else if (w_gnt_i) begin
        // The I port is read-only: no data, no strobes.
        r_owner <= PORT_I;
        r_req   <= '{addr:  bus.i_req_addr_i,
                     we:    1'b0,
                     wdata: '0,
                     wstrb: '0};
      end

      if (r_state == ISSUE && r_req.we) r_rdata <= '0;
      if (r_state == WAIT)              r_rdata <= bus.ram_rdata_i;
    end
  end

  // ---------------- RAM command ----------------
  // Word address of the line; the two word-in-line bits are always zero.
  assign bus.ram_addr_o  = {r_req.addr[AW+1:LINE_OFF_W], 2'b00};
  assign bus.ram_wdata_o = r_req.wdata;
  assign bus.ram_rd_en_o = (r_state == ISSUE) && !r_req.we;
  assign bus.ram_wstrb_o = (r_state == ISSUE && r_req.we) ? r_req.wstrb : '0;

  // Byte offset and bits above the RAM range are not part of the RAM address.
  assign w_unused_addr = ^{r_req.addr[ADDR_W-1:AW+2], r_req.addr[LINE_OFF_W-1:0]};

  // ---------------- Responses ----------------
  assign bus.d_rsp_valid_o = (r_state == RESP) && (r_owner == PORT_D);
  assign bus.i_rsp_valid_o = (r_state == RESP) && (r_owner == PORT_I);
  assign bus.d_rsp_rdata_o = (r_owner == PORT_D) ? r_rdata : '0;
  assign bus.i_rsp_rdata_o = (r_owner == PORT_I) ? r_rdata : '0;

  assign bus.busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural line-wide RAM (1-cycle
// registered read) and a shadow memory that predicts read data. Expected
// responses are queued at grant time and compared when the DUT responds.
// Build with RAM_ARB_RR_EN defined to exercise round-robin expectations.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

`ifdef RAM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  localparam logic [LINE_W-1:0] BASE_LINE = 128'h44444444_33333333_22222222_11111111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- Behavioural RAM ----------------
  logic [LINE_W-1:0] ram_mem  [64];
  logic [LINE_W-1:0] gold_mem [64];
  logic [LINE_W-1:0] ram_q;
  logic [5:0]        ram_li;

  assign ram_li          = bus.ram_addr_o[7:2];
  assign bus.ram_rdata_i = ram_q;

  always @(posedge clk) begin
    if (bus.ram_rd_en_o) ram_q <= ram_mem[ram_li];
    for (int b = 0; b < RAM_LINE_BYTES; b++)
      if (bus.ram_wstrb_o[b]) ram_mem[ram_li][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    ram_port_e         port;
    logic [LINE_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t      sb[$];
  int        compared   = 0;
  int        mismatched = 0;
  ram_port_e tb_ptr     = PORT_D;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input ram_port_e p);
    return (p == PORT_D) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input ram_port_e p, input logic [31:0] a, input logic we,
                         input logic [127:0] wd, input logic [15:0] ws);
    if (p == PORT_D) begin
      bus.d_req_valid_i = 1'b1;
      bus.d_req_addr_i  = a;
      bus.d_req_we_i    = we;
      bus.d_req_wdata_i = wd;
      bus.d_req_wstrb_i = ws;
    end else begin
      bus.i_req_valid_i = 1'b1;
      bus.i_req_addr_i  = a;
    end
  endtask

  // Waits for a grant, checks it went to port p, queues the expected response
  // and returns #1 after the accepting edge (DUT in ISSUE).
  task automatic accept(input ram_port_e p, input logic [31:0] a, input logic we,
                        input logic [127:0] wd, input logic [15:0] ws, output int acc);
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    int   li;
    acc = -1;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.d_req_ready_o || bus.i_req_ready_o) seen = 1'b1;
      else n++;
    end
    check("grant_seen", {255'd0, seen}, 256'd1);
    if (!seen) return;
    acc = cyc;
    check("grant_port", {bus.d_req_ready_o, bus.i_req_ready_o}, onehot(p));
    li     = int'(a[9:4]);
    e.port = p;
    e.cyc  = acc + (we ? 2 : 3);
    if (we) begin
      for (int b = 0; b < RAM_LINE_BYTES; b++)
        if (ws[b]) gold_mem[li][b*8 +: 8] = wd[b*8 +: 8];
      e.data = '0;
    end else begin
      e.data = gold_mem[li];
    end
    sb.push_back(e);
    tb_ptr = (p == PORT_D) ? PORT_I : PORT_D;
    @(posedge clk);
    #1;
    if (p == PORT_D) bus.d_req_valid_i = 1'b0;
    else             bus.i_req_valid_i = 1'b0;
  endtask

  // Checks the RAM command in ISSUE and, for reads, that it is gone in WAIT.
  task automatic check_issue(input logic [31:0] a, input logic we,
                             input logic [127:0] wd, input logic [15:0] ws);
    logic [14:0] ea;
    ea = {a[16:4], 2'b00};
    @(negedge clk);
    check("issue_cmd", {bus.ram_rd_en_o, bus.ram_addr_o, bus.ram_wstrb_o, bus.busy_o},
          {!we, ea, (we ? ws : 16'h0000), 1'b1});
    if (we) begin
      check("issue_wdata", bus.ram_wdata_o, wd);
    end else begin
      @(negedge clk);
      check("wait_ram_quiet", {bus.ram_rd_en_o, bus.ram_wstrb_o, bus.busy_o}, {1'b0, 16'h0000, 1'b1});
    end
  endtask

  // Waits for a response, compares it against the queue head, optionally
  // stalls rsp_ready for 'stall' more cycles, and returns #1 after handshake.
  task automatic wait_rsp(input int stall);
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.d_rsp_valid_o || bus.i_rsp_valid_o) seen = 1'b1;
      else n++;
    end
    check("rsp_seen", {255'd0, seen}, 256'd1);
    check("sb_depth", sb.size(), 256'd1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    check("rsp_cycle", cyc, e.cyc);
    check("rsp_port", {bus.d_rsp_valid_o, bus.i_rsp_valid_o}, onehot(e.port));
    check("rsp_data", (e.port == PORT_D) ? bus.d_rsp_rdata_o : bus.i_rsp_rdata_o, e.data);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_ctrl", {bus.d_rsp_valid_o, bus.i_rsp_valid_o, bus.ram_rd_en_o, bus.ram_wstrb_o, bus.busy_o},
            {onehot(e.port), 1'b0, 16'h0000, 1'b1});
      check("stall_data", (e.port == PORT_D) ? bus.d_rsp_rdata_o : bus.i_rsp_rdata_o, e.data);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1;
      bus.d_rsp_ready_i = 1'b1;
      bus.i_rsp_ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {bus.d_req_ready_o, bus.d_rsp_valid_o, bus.i_req_ready_o, bus.i_rsp_valid_o,
                           bus.ram_rd_en_o, bus.ram_wstrb_o, bus.ram_addr_o, bus.busy_o}, 256'd0);
    check({tag, "_rdata"}, {bus.d_rsp_rdata_o, bus.i_rsp_rdata_o}, 256'd0);
    check({tag, "_wdata"}, bus.ram_wdata_o, 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed sequence ----------------
  logic [31:0] d_addrs [2];
  logic [31:0] i_addrs [2];

  initial begin
    int        acc;
    int        fall;
    int        d_left;
    int        i_left;
    ram_port_e win;
    logic [31:0] wa;

    rst               = 1'b1;
    bus.d_req_valid_i = 1'b0;
    bus.d_req_addr_i  = '0;
    bus.d_req_we_i    = 1'b0;
    bus.d_req_wdata_i = '0;
    bus.d_req_wstrb_i = '0;
    bus.d_rsp_ready_i = 1'b1;
    bus.i_req_valid_i = 1'b0;
    bus.i_req_addr_i  = '0;
    bus.i_rsp_ready_i = 1'b1;
    bus.hold_i        = 1'b0;
    for (int l = 0; l < 64; l++) begin
      gold_mem[l] = BASE_LINE ^ {4{8'(l), 24'h000000}};
      ram_mem[l]  = gold_mem[l];
    end
    d_addrs[0] = 32'h0000_0100;
    d_addrs[1] = 32'h0000_0140;
    i_addrs[0] = 32'h0000_0200;
    i_addrs[1] = 32'h0000_0240;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // D read of line 0x40 (RAM word 0x10)
    set_req(PORT_D, 32'h0000_0040, 1'b0, '0, '0);
    accept(PORT_D, 32'h0000_0040, 1'b0, '0, '0, acc);
    check_issue(32'h0000_0040, 1'b0, '0, '0);
    wait_rsp(0);

    // D write of low word at 0x80, then read back
    set_req(PORT_D, 32'h0000_0080, 1'b1, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_DEADBEEF, 16'h000F);
    accept(PORT_D, 32'h0000_0080, 1'b1, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_DEADBEEF, 16'h000F, acc);
    check_issue(32'h0000_0080, 1'b1, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_DEADBEEF, 16'h000F);
    wait_rsp(0);
    set_req(PORT_D, 32'h0000_0080, 1'b0, '0, '0);
    accept(PORT_D, 32'h0000_0080, 1'b0, '0, '0, acc);
    check_issue(32'h0000_0080, 1'b0, '0, '0);
    wait_rsp(0);

    // Strobe-less write to 0x40 is acked; line unchanged afterwards
    set_req(PORT_D, 32'h0000_0040, 1'b1, {4{32'hFFFF_FFFF}}, 16'h0000);
    accept(PORT_D, 32'h0000_0040, 1'b1, {4{32'hFFFF_FFFF}}, 16'h0000, acc);
    check_issue(32'h0000_0040, 1'b1, {4{32'hFFFF_FFFF}}, 16'h0000);
    wait_rsp(0);
    set_req(PORT_D, 32'h0000_0040, 1'b0, '0, '0);
    accept(PORT_D, 32'h0000_0040, 1'b0, '0, '0, acc);
    check_issue(32'h0000_0040, 1'b0, '0, '0);
    wait_rsp(0);

    // hold raised during ISSUE of an I read; pending D waits for hold to drop
    set_req(PORT_I, 32'h0000_0240, 1'b0, '0, '0);
    accept(PORT_I, 32'h0000_0240, 1'b0, '0, '0, acc);
    bus.hold_i = 1'b1;
    set_req(PORT_D, 32'h0000_0100, 1'b0, '0, '0);
    check_issue(32'h0000_0240, 1'b0, '0, '0);
    wait_rsp(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_block", {bus.d_req_ready_o, bus.i_req_ready_o, bus.busy_o}, 256'd0);
    end
    @(posedge clk);
    #1 bus.hold_i = 1'b0;
    fall = cyc;
    accept(PORT_D, 32'h0000_0100, 1'b0, '0, '0, acc);
    check("hold_release_cycle", acc, fall);
    check_issue(32'h0000_0100, 1'b0, '0, '0);
    wait_rsp(0);

    // I read with response stalled for 5 cycles
    bus.i_rsp_ready_i = 1'b0;
    set_req(PORT_I, 32'h0000_0200, 1'b0, '0, '0);
    accept(PORT_I, 32'h0000_0200, 1'b0, '0, '0, acc);
    check_issue(32'h0000_0200, 1'b0, '0, '0);
    wait_rsp(5);

    // Contention: D and I both valid over 4 transactions
    d_left = 2;
    i_left = 2;
    for (int k = 0; k < 4; k++) begin
      if (d_left > 0 && !bus.d_req_valid_i) set_req(PORT_D, d_addrs[2-d_left], 1'b0, '0, '0);
      if (i_left > 0 && !bus.i_req_valid_i) set_req(PORT_I, i_addrs[2-i_left], 1'b0, '0, '0);
      if (d_left > 0 && i_left > 0) win = RR_MODE ? tb_ptr : PORT_D;
      else                          win = (d_left > 0) ? PORT_D : PORT_I;
      wa = (win == PORT_D) ? d_addrs[2-d_left] : i_addrs[2-i_left];
      accept(win, wa, 1'b0, '0, '0, acc);
      if (win == PORT_D) d_left--;
      else               i_left--;
      check_issue(wa, 1'b0, '0, '0);
      wait_rsp(0);
    end

    // Reset asserted in WAIT drops the transaction
    set_req(PORT_D, 32'h0000_0140, 1'b0, '0, '0);
    accept(PORT_D, 32'h0000_0140, 1'b0, '0, '0, acc);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("reset_in_wait");
    sb.delete();
    tb_ptr = PORT_D;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_rsp_after_reset", {bus.d_rsp_valid_o, bus.i_rsp_valid_o, bus.ram_rd_en_o, bus.busy_o}, 256'd0);
    end
    set_req(PORT_D, 32'h0000_0140, 1'b0, '0, '0);
    accept(PORT_D, 32'h0000_0140, 1'b0, '0, '0, acc);
    check_issue(32'h0000_0140, 1'b0, '0, '0);
    wait_rsp(0);

    check("sb_empty", sb.size(), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
